// File: rtl/dmem_arbiter_if.sv
// Core-side and memory-side bus bundle for the shared data-memory arbiter.
// The arbiter uses the slave view; whatever drives the cores and the RAM
// uses the master view.
interface dmem_arbiter_if #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16
);
  logic [NUM_CORES-1:0]        core_req;
  logic [NUM_CORES-1:0]        core_we;
  logic [NUM_CORES*ADDR_W-1:0] core_addr;
  logic [NUM_CORES*DATA_W-1:0] core_wdata;
  logic [NUM_CORES-1:0]        core_end;
  logic [DATA_W-1:0]           core_rdata;
  logic [NUM_CORES-1:0]        core_rvalid;
  logic [2*NUM_CORES-1:0]      core_status;
  logic                        mem_we;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic [DATA_W-1:0]           mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, core_end, mem_rdata,
    output core_rdata, core_rvalid, core_status, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, core_end, mem_rdata,
    input  core_rdata, core_rvalid, core_status, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter letting NUM_CORES cores share one synchronous data RAM.
// One grant per cycle, combinational from the registered round-robin pointer;
// read data returns one cycle after a read grant and is broadcast to all cores.
// Optional feature: define DMEM_ARB_STALL_CNT_EN to build the saturating
// stall-cycle counter; otherwise stall_count is tied to zero.
module dmem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  dmem_arbiter_if.slave       bus,
  output logic                done,
  output logic [15:0]         stall_count
);
  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t                 state_q;
  logic                   done_q;
  logic                   start_q;
  logic [NUM_CORES-1:0]   end_q;
  logic [PTR_W-1:0]       ptr_q;
  logic [PTR_W-1:0]       ptr_d;
  logic [NUM_CORES-1:0]   rvalid_q;

  logic                   start_rise;
  logic                   all_end;
  logic [NUM_CORES-1:0]   eligible;
  logic [NUM_CORES-1:0]   grant;
  logic [PTR_W-1:0]       grant_idx;
  logic [PTR_W-1:0]       cand;
  logic                   grant_vld;

  assign start_rise = start & ~start_q;
  assign all_end    = &end_q;
  // Finished cores drop out of arbitration even if they keep requesting.
  assign eligible   = (state_q == S_RUN) ? (bus.core_req & ~end_q) : '0;
  assign ptr_d      = (grant_idx == PTR_W'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;

  // Round-robin search starting at the core after the last one granted.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand = PTR_W'((int'(ptr_q) + k) % NUM_CORES);
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    for (int n = 0; n < NUM_CORES; n++) begin
      grant[n] = grant_vld && (grant_idx == PTR_W'(n));
    end
  end

  // Steer the granted core onto the RAM port; write enable is held off during reset.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    for (int n = 0; n < NUM_CORES; n++) begin
      if (grant[n]) begin
        bus.mem_we    = bus.core_we[n] & ~reset;
        bus.mem_addr  = bus.core_addr[n*ADDR_W +: ADDR_W];
        bus.mem_wdata = bus.core_wdata[n*DATA_W +: DATA_W];
      end
    end
  end

  // Per-core status: 00 idle, 01 running/granted, 10 stalled, 11 finished.
  always_comb begin
    bus.core_status = '0;
    for (int n = 0; n < NUM_CORES; n++) begin
      case (state_q)
        S_RUN: begin
          if (end_q[n])         bus.core_status[2*n +: 2] = 2'b11;
          else if (grant[n])    bus.core_status[2*n +: 2] = 2'b01;
          else if (eligible[n]) bus.core_status[2*n +: 2] = 2'b10;
          else                  bus.core_status[2*n +: 2] = 2'b01;
        end
        S_FIN:   bus.core_status[2*n +: 2] = 2'b11;
        default: bus.core_status[2*n +: 2] = 2'b00;
      endcase
    end
  end

  // Run-control FSM with start edge detect, sticky end latches, pointer and read-valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      end_q    <= '0;
      ptr_q    <= '0;
      rvalid_q <= '0;
    end else begin
      start_q  <= start;
      rvalid_q <= grant & ~bus.core_we;
      if (grant_vld) ptr_q <= ptr_d;
      case (state_q)
        S_IDLE: begin
          if (start_rise) begin
            state_q <= S_RUN;
            end_q   <= '0;
          end
        end
        S_RUN: begin
          end_q <= end_q | bus.core_end;
          if (all_end) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
          end
        end
        S_FIN: begin
          if (start_rise) begin
            state_q <= S_RUN;
            done_q  <= 1'b0;
            end_q   <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.core_rvalid = rvalid_q;
  assign bus.core_rdata  = bus.mem_rdata;
  assign done            = done_q;

`ifdef DMEM_ARB_STALL_CNT_EN
  logic [NUM_CORES-1:0] waits;
  logic [15:0]          stall_q;
  logic [16:0]          stall_sum;

  assign waits = eligible & ~grant;

  // Add this cycle's stalled cores to the running total, with a carry bit for saturation.
  always_comb begin
    stall_sum = {1'b0, stall_q};
    for (int n = 0; n < NUM_CORES; n++) begin
      stall_sum = stall_sum + 17'(waits[n]);
    end
  end

  // Saturating stall counter, restarted on every start edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (start_rise) begin
      stall_q <= '0;
    end else if (state_q == S_RUN) begin
      stall_q <= stall_sum[16] ? 16'hFFFF : stall_sum[15:0];
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = 16'h0000;
`endif
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter NUM_CORES, default 4: number of core_1-style cores sharing one data memory.
REQ-002 Parameter ADDR_W, default 8: data memory address width.
REQ-003 Parameter DATA_W, default 16: data word width.
REQ-004 Clocking SHALL be: one clock; reset is asynchronous and active-high.
REQ-005 Ports (name, direction, width, meaning):
- clock  in  1  system clock, rising-edge.
- reset  in  1  async active-high reset.
- start  in  1  level; rising edge begins a run.
- core_req  in  NUM_CORES  per-core data-memory access request.
- core_we  in  NUM_CORES  per-core write enable (write_en0).
- core_addr  in  NUM_CORES*ADDR_W  packed per-core address (addr_data_0); core n at [n*ADDR_W +: ADDR_W].
- core_wdata  in  NUM_CORES*DATA_W  packed per-core write data (datain0).
- core_end  in  NUM_CORES  per-core end_process.
- core_rdata  out  DATA_W  read data broadcast to all cores (dataout0).
- core_rvalid  out  NUM_CORES  one-hot; core_rdata valid for that core.
- core_status  out  2*NUM_CORES  packed per-core status; core n at [2n +: 2].
- mem_we  out  1  shared RAM write enable.
- mem_addr  out  ADDR_W  shared RAM address.
- mem_wdata  out  DATA_W  shared RAM write data.
- mem_rdata  in  DATA_W  shared RAM read data, synchronous, one-cycle latency.
- done  out  1  all cores finished.
- stall_count  out  16  total stall cycles, see Configuration.

Function
REQ-006 Status encoding SHALL be: 00 IDLE, 01 RUN/granted, 10 WAIT (stalled), 11 DONE.
REQ-007 FSM states SHALL be IDLE, RUN, FIN; IDLE->RUN on start rising edge; RUN->FIN when every end latch is set; FIN->RUN on the next start rising edge, which also clears all end latches.
REQ-008 In IDLE, all core_status SHALL be 00, mem_we 0, no grant.
REQ-009 In RUN, exactly one requesting, unfinished core SHALL be granted per cycle, round-robin starting at the core after the last granted core (pointer resets to 0, so core 0 has first priority).
REQ-010 Grant SHALL be combinational from registered pointer and current core_req; mem_we/mem_addr/mem_wdata SHALL be muxed from the granted core in the same cycle; mem_we SHALL be 0 when no grant.
REQ-011 In RUN, status per core: granted -> 01; requesting but not granted -> 10; not requesting and unfinished -> 01; end latch set -> 11.
REQ-012 core_rvalid[n] SHALL assert exactly one cycle after a read grant (core_we=0) to core n; core_rdata SHALL pass mem_rdata unregistered. No rvalid for writes.
REQ-013 core_end[n] SHALL set a sticky end latch on the clock edge; a request presented in the same cycle as core_end SHALL still be served.
REQ-014 A finished core's core_req SHALL be ignored.
REQ-015 done SHALL be 1 in FIN only; in FIN all statuses SHALL be 11.
REQ-016 start held high SHALL NOT retrigger; only a 0->1 transition (registered edge detect) counts.

Reset
REQ-017 Asserting reset at any time, including mid-access, SHALL immediately force state IDLE, pointer 0, end latches 0, core_rvalid 0, done 0, stall_count 0, start edge register 0; mem_we SHALL be 0 while reset is high.

Configuration
REQ-018 Macro DMEM_ARB_STALL_CNT_EN: when defined, stall_count SHALL increment by the number of cores in WAIT each RUN cycle, saturating at 16'hFFFF, cleared by reset and by each start rising edge; when undefined, stall_count SHALL be constant 0 and no counter logic is built.

Verification
REQ-019 Reset then start pulse, only core 2 requests read addr 8'h10, RAM holds 16'h1234 -> mem_addr 8'h10 same cycle, core_rvalid=4'b0100 and core_rdata 16'h1234 next cycle, status core 2 = 01.
REQ-020 All four cores request continuously -> grants 0,1,2,3,0,... one per cycle; each cycle three statuses 10; stall_count +3 per cycle (macro on), stays 0 (macro off).
REQ-021 Core 1 writes 16'hBEEF to 8'h20 while core 0 requests -> core 0 granted first, then core 1 with mem_we=1, addr 8'h20, data 16'hBEEF; no rvalid for core 1.
REQ-022 Core 3 asserts core_end and core_req same cycle -> request served, core 3 status 11 afterwards, later core_req[3] ignored; after all four ends -> done=1, all statuses 11; new start edge -> done=0, RUN.
REQ-023 Reset asserted during a granted write -> mem_we drops to 0 immediately, all outputs at reset values, start required to run again.
